// File: rtl/stage_controller.sv
// rtl/stage_controller.sv - game-stage sequencer: title/battle/victory/defeat flags and fight-start pulse
module stage_controller #(
  parameter int HOLD_FRAMES = 180,
  parameter int HP_W        = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_clk,
  input  logic            start_key,
  input  logic [HP_W-1:0] hp_p1,
  input  logic [HP_W-1:0] hp_p2,
  output logic            start_l,
  output logic            battle_l,
  output logic            win_l,
  output logic            lose_l,
  output logic            game_reset,
  output logic [7:0]      stage_frames
);

  typedef enum logic [3:0] {
    ST_START  = 4'b0001,
    ST_BATTLE = 4'b0010,
    ST_WIN    = 4'b0100,
    ST_LOSE   = 4'b1000
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_t state;
  state_t next_state;
  logic   armed;
  logic   f1, f2, f3;
  logic   k1, k2, k3;
  logic   frame_tick;
  logic   key_press;

  // Two-flop synchronisers plus a delay flop for rising-edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {f3, f2, f1} <= 3'b000;
      {k3, k2, k1} <= 3'b000;
    end else begin
      {f3, f2, f1} <= {f2, f1, frame_clk};
      {k3, k2, k1} <= {k2, k1, start_key};
    end
  end

  assign frame_tick = f2 & ~f3;
  assign key_press  = k2 & ~k3;

  always_comb begin
    next_state = state;
    case (state)
      ST_START:  if (key_press) next_state = ST_BATTLE;
      ST_BATTLE: begin
        // A double knockout counts as a defeat, so hp_p1 is tested first.
        if (armed && hp_p1 == '0)      next_state = ST_LOSE;
        else if (armed && hp_p2 == '0) next_state = ST_WIN;
      end
      ST_WIN, ST_LOSE:
        if (frame_tick && stage_frames == HOLD_LAST) next_state = ST_START;
      default: next_state = ST_START;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= ST_START;
      armed        <= 1'b0;
      game_reset   <= 1'b0;
      stage_frames <= 8'd0;
    end else begin
      state      <= next_state;
      game_reset <= (state == ST_START) && (next_state == ST_BATTLE);
      if (next_state != state) begin
        stage_frames <= 8'd0;
        armed        <= 1'b0;
      end else begin
        if (frame_tick && stage_frames != 8'hFF)
          stage_frames <= stage_frames + 8'd1;
        // Health registers may still be reloading until the first frame of the fight.
        if (state == ST_BATTLE && frame_tick)
          armed <= 1'b1;
      end
    end
  end

  assign start_l  = state[0];
  assign battle_l = state[1];
  assign win_l    = state[2];
  assign lose_l   = state[3];

endmodule

// File: tb/tb_stage_controller.sv
// tb/tb_stage_controller.sv - table-driven bench for stage_controller with HOLD_FRAMES = 3
module tb_stage_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       start_key = 1'b0;
  logic [7:0] hp_p1 = 8'd10;
  logic [7:0] hp_p2 = 8'd10;
  logic       start_l, battle_l, win_l, lose_l, game_reset;
  logic [7:0] stage_frames;

  int errors = 0;
  int checks = 0;
  int gr_count = 0;

  stage_controller #(.HOLD_FRAMES(3), .HP_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_key(start_key),
    .hp_p1(hp_p1), .hp_p2(hp_p2),
    .start_l(start_l), .battle_l(battle_l), .win_l(win_l), .lose_l(lose_l),
    .game_reset(game_reset), .stage_frames(stage_frames)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (game_reset) gr_count++;

  typedef struct {
    logic [7:0] hp1;
    logic [7:0] hp2;
    int         key;
    int         frames;
    logic [3:0] exp_flags;
    logic [7:0] exp_sf;
  } vec_t;

  localparam logic [3:0] FS = 4'b0001, FB = 4'b0010, FW = 4'b0100, FL = 4'b1000;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {lose_l, win_l, battle_l, start_l};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1; cyc(4);
    frame_clk = 1'b0; cyc(4);
  endtask

  task automatic key_hold(input int n);
    start_key = 1'b1; cyc(n);
    start_key = 1'b0; cyc(4);
  endtask

  initial begin
    vecs[0]  = '{8'd0,  8'd10, 0, 0, FB, 8'd0};
    vecs[1]  = '{8'd5,  8'd10, 0, 1, FB, 8'd1};
    vecs[2]  = '{8'd5,  8'd10, 6, 0, FB, 8'd1};
    vecs[3]  = '{8'd5,  8'd0,  0, 0, FW, 8'd0};
    vecs[4]  = '{8'd10, 8'd10, 0, 1, FW, 8'd1};
    vecs[5]  = '{8'd10, 8'd10, 0, 1, FW, 8'd2};
    vecs[6]  = '{8'd10, 8'd10, 0, 1, FS, 8'd0};
    vecs[7]  = '{8'd10, 8'd10, 4, 0, FB, 8'd0};
    vecs[8]  = '{8'd10, 8'd10, 0, 1, FB, 8'd1};
    vecs[9]  = '{8'd0,  8'd0,  0, 0, FL, 8'd0};
    vecs[10] = '{8'd0,  8'd0,  4, 0, FL, 8'd0};
    vecs[11] = '{8'd10, 8'd10, 0, 1, FL, 8'd1};
    vecs[12] = '{8'd10, 8'd10, 0, 1, FL, 8'd2};
    vecs[13] = '{8'd10, 8'd10, 0, 1, FS, 8'd0};
    vecs[14] = '{8'd10, 8'd10, 4, 0, FB, 8'd0};
    vecs[15] = '{8'd10, 8'd10, 0, 1, FB, 8'd1};
    vecs[16] = '{8'd10, 8'd0,  0, 0, FW, 8'd0};
    vecs[17] = '{8'd10, 8'd0,  0, 1, FW, 8'd1};

    cyc(3);
    chk("reset_flags", 32'(flags()), 32'(FS));
    chk("reset_sf", 32'(stage_frames), 0);
    chk("reset_game_reset", 32'(game_reset), 0);
    Reset = 1'b0;
    cyc(2);

    // Idle in START: count then saturate.
    frame_pulse();
    chk("idle_sf1", 32'(stage_frames), 1);
    frame_pulse();
    chk("idle_sf2", 32'(stage_frames), 2);
    repeat (253) frame_pulse();
    chk("idle_sf255", 32'(stage_frames), 255);
    repeat (3) frame_pulse();
    chk("idle_sf_sat", 32'(stage_frames), 255);
    chk("idle_flags", 32'(flags()), 32'(FS));

    // Long key hold: single press, battle three edges after drive.
    start_key = 1'b1;
    cyc(2);
    chk("key_lat_not_yet", 32'(battle_l), 0);
    cyc(1);
    chk("key_lat_battle", 32'(flags()), 32'(FB));
    chk("key_gr_high", 32'(game_reset), 1);
    chk("key_sf_clear", 32'(stage_frames), 0);
    cyc(1);
    chk("key_gr_low", 32'(game_reset), 0);
    cyc(996);
    start_key = 1'b0;
    cyc(4);
    chk("key_one_pulse", 32'(gr_count), 1);
    chk("key_still_battle", 32'(flags()), 32'(FB));

    for (int i = 0; i < 18; i++) begin
      hp_p1 = vecs[i].hp1;
      hp_p2 = vecs[i].hp2;
      cyc(2);
      if (vecs[i].key > 0) key_hold(vecs[i].key);
      repeat (vecs[i].frames) frame_pulse();
      chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
      chk($sformatf("vec%0d_sf", i), 32'(stage_frames), 32'(vecs[i].exp_sf));
    end
    chk("gr_count_table", 32'(gr_count), 3);

    // Asynchronous reset in WIN, checked between clock edges.
    Reset = 1'b1;
    #2;
    chk("async_flags", 32'(flags()), 32'(FS));
    chk("async_sf", 32'(stage_frames), 0);
    cyc(1);
    Reset = 1'b0;
    hp_p1 = 8'd10; hp_p2 = 8'd10;
    cyc(2);
    key_hold(4);
    chk("post_reset_battle", 32'(flags()), 32'(FB));
    chk("post_reset_gr", 32'(gr_count), 4);

    // Health to WIN takes one edge once armed.
    frame_pulse();
    hp_p2 = 8'd0;
    chk("hp_edge_before", 32'(win_l), 0);
    cyc(1);
    chk("hp_edge_after", 32'(win_l), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
